sprattr_scan: RTL
=================

Name: sprattr_scan

Overview:
- Parametrised sprite attribute store with an integrated per-line sprite evaluator. Successor to the fixed 64-entry attribute RAM.
- The CPU side uses the same I/O register window (VSPRSEL..VSPRATTR) plus a new status register.
- The video side no longer addresses sprites directly. It pulses line_start, and the block scans all sprites and streams the ones that hit that line over a valid/ready interface to the sprite line renderer.

Parameters:
- SPR_BITS, 6, log2 of sprite count (NUM_SPR = 2**SPR_BITS, legal 4..8).
- MAX_PER_LINE, 16, maximum hits emitted per scan (legal 1..63).

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- io_addr  in  4  register select: 4=VSPRSEL, 5=VSPRX_L, 6=VSPRX_H, 7=VSPRY, 8=VSPRIDX, 9=VSPRATTR, A=VSPRSTAT
- io_rddata  out  8  combinational read data
- io_wrdata  in  8  write data
- io_wren  in  1  write strobe
- line_start  in  1  one-cycle pulse; start scan for line
- line  in  8  line number, sampled when line_start=1
- hit_valid  out  1  hit record available
- hit_ready  in  1  consumer accepts record
- hit_sel  out  SPR_BITS  sprite number
- hit_x  out  9  sprite X
- hit_idx  out  9  tile index
- hit_row  out  4  row within sprite, vflip applied
- hit_attr  out  6  {priority, palette[1:0], h16, vflip, hflip}
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at end of scan

Behaviour:
- Storage: NUM_SPR x 33 bits, dual-port distributed RAM.
  - Port A: CPU, synchronous write, async read at sprsel_r.
  - Port B: scan, async read at scan counter.
  - Contents are not reset.
- Field layout: VSPRATTR bits are [7]=enable, [6]=priority, [5:4]=palette, [3]=h16, [2]=vflip, [1]=hflip, [0]=idx[8]. VSPRX_H holds bit 0 only (x[8]).
- I/O reads:
  - VSPRSEL returns sprsel_r zero-extended.
  - VSPRX_H returns {7'b0, x[8]}.
  - VSPRSTAT returns {overflow, busy, hit_count[5:0]}.
  - Unused addresses return 0.
  - VSPRSTAT is read-only; writes to it are ignored.
- VSPRSEL write: sprsel_r <= io_wrdata[SPR_BITS-1:0].
- Write/scan collision: a CPU write and a scan read of the same entry in the same cycle; the scan sees the old value.
- Reset: sprsel_r=0, FSM=IDLE, hit_valid=0, scan_busy=0, scan_done=0, overflow=0, hit_count=0, all hit_* outputs=0.
- FSM states:
  - IDLE -> SCAN on line_start. Latch line, clear counter, hit_count and overflow.
  - SCAN evaluates entry[counter], one sprite per cycle.
    - dy = (line - y) mod 256.
    - Hit if enable && dy < (h16 ? 16 : 8).
    - Row = vflip ? (h16 ? 15-dy : 7-dy) : dy, 4 bits, upper bit 0 for 8-high sprites.
    - On a hit with hit_count < MAX_PER_LINE: register the record, assert hit_valid, go to EMIT.
    - On a hit with hit_count == MAX_PER_LINE: set overflow, go to FINISH.
    - No hit: increment counter; if counter was NUM_SPR-1, go to FINISH.
  - EMIT holds the record stable while hit_valid && !hit_ready.
    - On handshake: hit_valid=0, hit_count+1.
    - If counter == NUM_SPR-1, go to FINISH; else increment counter and return to SCAN.
  - FINISH: scan_done=1 for one cycle, then IDLE.
- scan_busy=1 in SCAN, EMIT and FINISH.
- line_start while not IDLE: abort, drop any pending record (hit_valid=0 next cycle), restart SCAN with the new line. No scan_done for the aborted scan.
- overflow and hit_count hold until the next line_start.
- Scan order: ascending sprite number; lowest number emitted first.

Optional Feature:
- Macro SPRATTR_AUTOINC_EN.
- Defined: a CPU write to VSPRATTR increments sprsel_r by 1 after the write, wrapping NUM_SPR-1 -> 0. A write to VSPRSEL in the same cycle is impossible (single io_addr).
- Undefined: sprsel_r changes only on VSPRSEL writes.

Test Plan:
- Reset, then read VSPRSEL/VSPRSTAT -> 0x00/0x00. Write sprite 5: X=0x123, Y=0x40, IDX=0x1AB, ATTR=0x81 | h16. Read back -> X_L=0x23, X_H=0x01, Y=0x40, IDX=0xAB, ATTR as written.
- All sprites disabled except 3 (Y=10, 8-high) and 9 (Y=8, h16, vflip); line_start line=12, hit_ready=1 -> records sel=3 row=2, then sel=9 row=11; scan_done; VSPRSTAT=0x02.
- Y=250, 16-high, line=3 (wrap, dy=9) -> hit row=9. Y=250, 8-high -> no hit.
- MAX_PER_LINE=16, 20 sprites enabled on line 0 -> 16 records, overflow=1, VSPRSTAT=0x90 after scan.
- hit_ready held low 5 cycles -> record fields stable, hit_valid held. line_start mid-EMIT -> hit_valid drops next cycle, new scan restarts from sprite 0.
- With SPRATTR_AUTOINC_EN: VSPRSEL=63 (SPR_BITS=6), write VSPRATTR twice -> sprites 63 and 0 written; VSPRSEL reads 1.

Source files
------------

// File: rtl/sprattr_scan_if.sv
// CPU register-window bus plus the per-line scan request and hit-record stream
// of the sprite attribute store. The slave modport is the store's view.
interface sprattr_scan_if #(
    parameter int SPR_BITS = 6
);
    logic [3:0]          io_addr;
    logic [7:0]          io_rddata;
    logic [7:0]          io_wrdata;
    logic                io_wren;
    logic                line_start;
    logic [7:0]          line;
    logic                hit_valid;
    logic                hit_ready;
    logic [SPR_BITS-1:0] hit_sel;
    logic [8:0]          hit_x;
    logic [8:0]          hit_idx;
    logic [3:0]          hit_row;
    logic [5:0]          hit_attr;
    logic                scan_busy;
    logic                scan_done;

    modport slave (
        input  io_addr, io_wrdata, io_wren, line_start, line, hit_ready,
        output io_rddata, hit_valid, hit_sel, hit_x, hit_idx, hit_row,
               hit_attr, scan_busy, scan_done
    );

    modport master (
        output io_addr, io_wrdata, io_wren, line_start, line, hit_ready,
        input  io_rddata, hit_valid, hit_sel, hit_x, hit_idx, hit_row,
               hit_attr, scan_busy, scan_done
    );
endinterface

// File: rtl/sprattr_scan.sv
// Sprite attribute store with a per-line evaluator streaming hit records.
// Optional: SPRATTR_AUTOINC_EN makes VSPRATTR writes advance VSPRSEL.
module sprattr_scan #(
    parameter int SPR_BITS     = 6,
    parameter int MAX_PER_LINE = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    sprattr_scan_if.slave  bus
);
    localparam int NUM_SPR = 2 ** SPR_BITS;
    localparam logic [SPR_BITS-1:0] LAST = SPR_BITS'(NUM_SPR - 1);

    typedef struct packed {
        logic       en;
        logic       pri;
        logic [1:0] pal;
        logic       h16;
        logic       vflip;
        logic       hflip;
        logic [8:0] idx;
        logic [7:0] y;
        logic [8:0] x;
    } spr_t;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, FINISH} state_t;

    spr_t                mem [NUM_SPR];
    spr_t                cur, wr_ent, sent;
    logic [SPR_BITS-1:0] sprsel_r, cnt;
    logic                fld_wr;
    logic [7:0]          rd;

    state_t              state;
    logic [7:0]          line_r, dy;
    logic                hit;
    logic [3:0]          row;
    logic [5:0]          hit_count;
    logic                overflow;
    logic                hit_valid, scan_busy, scan_done;
    logic [SPR_BITS-1:0] hit_sel;
    logic [8:0]          hit_x, hit_idx;
    logic [3:0]          hit_row;
    logic [5:0]          hit_attr;

    assign cur    = mem[sprsel_r];
    assign sent   = mem[cnt];
    assign fld_wr = bus.io_wren && (bus.io_addr >= 4'h5) && (bus.io_addr <= 4'h9);

    // Field writes merge into the selected entry; the scan port sees the old
    // word during the write cycle because the array updates on the edge.
    always_comb begin
        wr_ent = cur;
        case (bus.io_addr)
            4'h5: wr_ent.x[7:0]   = bus.io_wrdata;
            4'h6: wr_ent.x[8]     = bus.io_wrdata[0];
            4'h7: wr_ent.y        = bus.io_wrdata;
            4'h8: wr_ent.idx[7:0] = bus.io_wrdata;
            4'h9: {wr_ent.en, wr_ent.pri, wr_ent.pal, wr_ent.h16,
                   wr_ent.vflip, wr_ent.hflip, wr_ent.idx[8]} = bus.io_wrdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk)
        if (fld_wr) mem[sprsel_r] <= wr_ent;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sprsel_r <= '0;
        else if (bus.io_wren && bus.io_addr == 4'h4)
            sprsel_r <= bus.io_wrdata[SPR_BITS-1:0];
`ifdef SPRATTR_AUTOINC_EN
        else if (bus.io_wren && bus.io_addr == 4'h9)
            sprsel_r <= sprsel_r + 1'b1;
`endif
    end

    always_comb begin
        rd = '0;
        case (bus.io_addr)
            4'h4: rd = 8'(sprsel_r);
            4'h5: rd = cur.x[7:0];
            4'h6: rd = {7'b0, cur.x[8]};
            4'h7: rd = cur.y;
            4'h8: rd = cur.idx[7:0];
            4'h9: rd = {cur.en, cur.pri, cur.pal, cur.h16, cur.vflip, cur.hflip, cur.idx[8]};
            4'hA: rd = {overflow, scan_busy, hit_count};
            default: rd = '0;
        endcase
    end
    assign bus.io_rddata = rd;

    // Evaluator: vertical distance wraps mod 256 so sprites straddle line 0.
    always_comb begin
        dy  = line_r - sent.y;
        hit = sent.en && (sent.h16 ? (dy < 8'd16) : (dy < 8'd8));
        if (!sent.vflip)   row = dy[3:0];
        else if (sent.h16) row = 4'd15 - dy[3:0];
        else               row = {1'b0, 3'd7 - dy[2:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            line_r    <= '0;
            cnt       <= '0;
            hit_count <= '0;
            overflow  <= 1'b0;
            hit_valid <= 1'b0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            hit_sel   <= '0;
            hit_x     <= '0;
            hit_idx   <= '0;
            hit_row   <= '0;
            hit_attr  <= '0;
        end else if (bus.line_start) begin
            // Also the abort path: any pending record is dropped, no done pulse.
            state     <= SCAN;
            line_r    <= bus.line;
            cnt       <= '0;
            hit_count <= '0;
            overflow  <= 1'b0;
            hit_valid <= 1'b0;
            scan_busy <= 1'b1;
            scan_done <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SCAN: begin
                    if (hit && hit_count < 6'(MAX_PER_LINE)) begin
                        hit_sel   <= cnt;
                        hit_x     <= sent.x;
                        hit_idx   <= sent.idx;
                        hit_row   <= row;
                        hit_attr  <= {sent.pri, sent.pal, sent.h16, sent.vflip, sent.hflip};
                        hit_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (hit) begin
                        overflow  <= 1'b1;
                        scan_done <= 1'b1;
                        state     <= FINISH;
                    end else if (cnt == LAST) begin
                        scan_done <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.hit_ready) begin
                        hit_valid <= 1'b0;
                        hit_count <= hit_count + 1'b1;
                        if (cnt == LAST) begin
                            scan_done <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                FINISH: begin
                    scan_done <= 1'b0;
                    scan_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hit_valid = hit_valid;
    assign bus.hit_sel   = hit_sel;
    assign bus.hit_x     = hit_x;
    assign bus.hit_idx   = hit_idx;
    assign bus.hit_row   = hit_row;
    assign bus.hit_attr  = hit_attr;
    assign bus.scan_busy = scan_busy;
    assign bus.scan_done = scan_done;
endmodule
